calc_req_tracker: RTL and testbench

//  Parametrised N-port request issuer and response tracker for the calc-style DUT port protocol.
//  - Per port: accepts host commands (valid/ready) and allocates a free tag.
//  - Drives req<n>_cmd/d1/d2/r1/tag/data toward the DUT.
//  - Matches out<n>_resp/tag/data back to outstanding tags.
//  - Reports completions, timeouts and spurious responses. Sits between the stimulus layer and the DUT pins.

---
 rtl/calc_req_tracker_if.sv | 52 +++++
 rtl/calc_req_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_calc_req_tracker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_req_tracker_if.sv
// Host / DUT / completion bundle for calc_req_tracker. Per-port fields are
// packed with port 0 in the least-significant slot.
interface calc_req_tracker_if #(
  parameter int NUM_PORTS = 4,
  parameter int TAG_W     = 2,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 4,
  parameter int CMD_W     = 4
);
  // host command side
  logic [NUM_PORTS-1:0]             host_valid;
  logic [NUM_PORTS-1:0]             host_ready;
  logic [NUM_PORTS-1:0][CMD_W-1:0]  host_cmd;
  logic [NUM_PORTS-1:0][REG_W-1:0]  host_d1;
  logic [NUM_PORTS-1:0][REG_W-1:0]  host_d2;
  logic [NUM_PORTS-1:0][REG_W-1:0]  host_r1;
  logic [NUM_PORTS-1:0][DATA_W-1:0] host_data;
  // toward the DUT request pins
  logic [NUM_PORTS-1:0][CMD_W-1:0]  req_cmd;
  logic [NUM_PORTS-1:0][REG_W-1:0]  req_d1;
  logic [NUM_PORTS-1:0][REG_W-1:0]  req_d2;
  logic [NUM_PORTS-1:0][REG_W-1:0]  req_r1;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data;
  // from the DUT response pins
  logic [NUM_PORTS-1:0][1:0]        out_resp;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  out_tag;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;
  // completion reporting
  logic [NUM_PORTS-1:0]             cpl_valid;
  logic [NUM_PORTS-1:0][1:0]        cpl_resp;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  cpl_tag;
  logic [NUM_PORTS-1:0][DATA_W-1:0] cpl_data;
  logic [NUM_PORTS-1:0]             cpl_timeout;
  logic [NUM_PORTS-1:0]             err_spurious;

  // tracker side
  modport master (
    input  host_valid, host_cmd, host_d1, host_d2, host_r1, host_data,
    input  out_resp, out_tag, out_data,
    output host_ready, req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
    output cpl_valid, cpl_resp, cpl_tag, cpl_data, cpl_timeout, err_spurious
  );

  // stimulus / DUT-model side
  modport slave (
    output host_valid, host_cmd, host_d1, host_d2, host_r1, host_data,
    output out_resp, out_tag, out_data,
    input  host_ready, req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
    input  cpl_valid, cpl_resp, cpl_tag, cpl_data, cpl_timeout, err_spurious
  );
endinterface

// File: rtl/calc_req_tracker.sv
// N-port request issuer / response tracker. Each port owns 2**TAG_W tags,
// issues host commands toward the DUT with the lowest free tag, matches
// responses back to outstanding tags and forces completion on timeout.

// One independent port: free bitmap, per-tag timeout counters, issue and
// completion registers.
module calc_req_tracker_port #(
  parameter int TAG_W   = 2,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic [CMD_W-1:0]  i_host_cmd,
  input  logic [REG_W-1:0]  i_host_d1,
  input  logic [REG_W-1:0]  i_host_d2,
  input  logic [REG_W-1:0]  i_host_r1,
  input  logic [DATA_W-1:0] i_host_data,
  output logic [CMD_W-1:0]  o_req_cmd,
  output logic [REG_W-1:0]  o_req_d1,
  output logic [REG_W-1:0]  o_req_d2,
  output logic [REG_W-1:0]  o_req_r1,
  output logic [TAG_W-1:0]  o_req_tag,
  output logic [DATA_W-1:0] o_req_data,
  input  logic [1:0]        i_out_resp,
  input  logic [TAG_W-1:0]  i_out_tag,
  input  logic [DATA_W-1:0] i_out_data,
  output logic              o_cpl_valid,
  output logic [1:0]        o_cpl_resp,
  output logic [TAG_W-1:0]  o_cpl_tag,
  output logic [DATA_W-1:0] o_cpl_data,
  output logic              o_cpl_timeout,
  output logic              o_err_spurious
);
  localparam int NT    = 1 << TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT);
  // A counter sitting at CNT_MAX while its tag is outstanding means the tag
  // has been waiting TIMEOUT cycles; it stays there until the tag completes,
  // so expiries that lose arbitration are remembered without extra state.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [NT-1:0]    r_free;
  logic [CNT_W-1:0] r_cnt [NT];

  logic [NT-1:0]    w_exp;
  logic [NT-1:0]    w_alloc_oh;
  logic [NT-1:0]    w_done_oh;
  logic [TAG_W-1:0] w_alloc_tag;
  logic [TAG_W-1:0] w_tmo_tag;
  logic             w_accept;
  logic             w_rsp_hit;
  logic             w_rsp_spur;
  logic             w_tmo_fire;

  assign o_host_ready = |r_free;

  // Pick lowest free tag and lowest expired tag; a real response wins the
  // single completion slot over any expiry.
  always_comb begin
    w_alloc_tag = '0;
    w_tmo_tag   = '0;
    w_exp       = '0;
    w_alloc_oh  = '0;
    w_done_oh   = '0;
    for (int t = NT - 1; t >= 0; t--) begin
      w_exp[t] = ~r_free[t] & (r_cnt[t] == CNT_MAX);
      if (r_free[t]) w_alloc_tag = TAG_W'(t);
      if (w_exp[t])  w_tmo_tag   = TAG_W'(t);
    end
    w_accept   = i_host_valid & o_host_ready;
    w_rsp_hit  = (i_out_resp != 2'b00) & ~r_free[i_out_tag];
    w_rsp_spur = (i_out_resp != 2'b00) &  r_free[i_out_tag];
    w_tmo_fire = (|w_exp) & ~w_rsp_hit;
    if (w_accept) w_alloc_oh[w_alloc_tag] = 1'b1;
    if (w_rsp_hit)       w_done_oh[i_out_tag] = 1'b1;
    else if (w_tmo_fire) w_done_oh[w_tmo_tag] = 1'b1;
  end

  // Tag bookkeeping: allocation sees the pre-edge bitmap, so a tag freed
  // this edge is only reusable from the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free <= '1;
      for (int t = 0; t < NT; t++) r_cnt[t] <= '0;
    end else begin
      r_free <= (r_free & ~w_alloc_oh) | w_done_oh;
      for (int t = 0; t < NT; t++) begin
        if (w_alloc_oh[t])
          r_cnt[t] <= '0;
        else if (!r_free[t] && r_cnt[t] != CNT_MAX)
          r_cnt[t] <= r_cnt[t] + 1'b1;
      end
    end
  end

  // Request pins carry an accepted command for exactly one cycle, else zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_req_cmd  <= '0;
      o_req_d1   <= '0;
      o_req_d2   <= '0;
      o_req_r1   <= '0;
      o_req_tag  <= '0;
      o_req_data <= '0;
    end else begin
      o_req_cmd  <= '0;
      o_req_d1   <= '0;
      o_req_d2   <= '0;
      o_req_r1   <= '0;
      o_req_tag  <= '0;
      o_req_data <= '0;
      if (w_accept) begin
        o_req_cmd  <= i_host_cmd;
        o_req_d1   <= i_host_d1;
        o_req_d2   <= i_host_d2;
        o_req_r1   <= i_host_r1;
        o_req_tag  <= w_alloc_tag;
        o_req_data <= i_host_data;
      end
    end
  end

  // Completion pulse (response or forced timeout) and sticky spurious flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cpl_valid    <= 1'b0;
      o_cpl_resp     <= '0;
      o_cpl_tag      <= '0;
      o_cpl_data     <= '0;
      o_cpl_timeout  <= 1'b0;
      o_err_spurious <= 1'b0;
    end else begin
      o_cpl_valid   <= 1'b0;
      o_cpl_resp    <= '0;
      o_cpl_tag     <= '0;
      o_cpl_data    <= '0;
      o_cpl_timeout <= 1'b0;
      if (w_rsp_hit) begin
        o_cpl_valid <= 1'b1;
        o_cpl_resp  <= i_out_resp;
        o_cpl_tag   <= i_out_tag;
        o_cpl_data  <= i_out_data;
      end else if (w_tmo_fire) begin
        o_cpl_valid   <= 1'b1;
        o_cpl_tag     <= w_tmo_tag;
        o_cpl_timeout <= 1'b1;
      end
      if (w_rsp_spur) o_err_spurious <= 1'b1;
    end
  end
endmodule

// Top: one tracker port per lane of the bundle.
module calc_req_tracker #(
  parameter int NUM_PORTS = 4,
  parameter int TAG_W     = 2,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 4,
  parameter int CMD_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic clk,
  input  logic reset,
  calc_req_tracker_if.master bus
);
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_req_tracker_port #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W),
      .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)
    ) u_port (
      .clk           (clk),
      .reset         (reset),
      .i_host_valid  (bus.host_valid[p]),
      .o_host_ready  (bus.host_ready[p]),
      .i_host_cmd    (bus.host_cmd[p]),
      .i_host_d1     (bus.host_d1[p]),
      .i_host_d2     (bus.host_d2[p]),
      .i_host_r1     (bus.host_r1[p]),
      .i_host_data   (bus.host_data[p]),
      .o_req_cmd     (bus.req_cmd[p]),
      .o_req_d1      (bus.req_d1[p]),
      .o_req_d2      (bus.req_d2[p]),
      .o_req_r1      (bus.req_r1[p]),
      .o_req_tag     (bus.req_tag[p]),
      .o_req_data    (bus.req_data[p]),
      .i_out_resp    (bus.out_resp[p]),
      .i_out_tag     (bus.out_tag[p]),
      .i_out_data    (bus.out_data[p]),
      .o_cpl_valid   (bus.cpl_valid[p]),
      .o_cpl_resp    (bus.cpl_resp[p]),
      .o_cpl_tag     (bus.cpl_tag[p]),
      .o_cpl_data    (bus.cpl_data[p]),
      .o_cpl_timeout (bus.cpl_timeout[p]),
      .o_err_spurious(bus.err_spurious[p])
    );
  end
endmodule

// File: tb/tb_calc_req_tracker.sv
// Scoreboard bench for calc_req_tracker: expected request beats and
// completions are queued when stimulus is driven and matched (including the
// cycle they must appear in) by a monitor on the falling edge.
module tb_calc_req_tracker;
  localparam int NP = 4, TW = 2, DW = 32, RW = 4, CW = 4, TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_req_tracker_if #(.NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW), .REG_W(RW), .CMD_W(CW)) bus ();

  calc_req_tracker #(
    .NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW), .REG_W(RW), .CMD_W(CW), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int            port;
    int            cyc;
    logic [CW-1:0] cmd;
    logic [RW-1:0] d1;
    logic [RW-1:0] d2;
    logic [RW-1:0] r1;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } req_e;

  typedef struct {
    int            port;
    int            cyc;
    logic [1:0]    resp;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          tmo;
  } cpl_e;

  req_e rq[$];
  cpl_e cq[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.host_valid = '0;
    bus.out_resp   = '0;
  endtask

  task automatic drive_host(input int p, input logic [CW-1:0] cmd, input logic [RW-1:0] d1,
                            input logic [RW-1:0] d2, input logic [RW-1:0] r1,
                            input logic [DW-1:0] data, input logic [TW-1:0] etag, input bit push);
    bus.host_valid[p] = 1'b1;
    bus.host_cmd[p]   = cmd;
    bus.host_d1[p]    = d1;
    bus.host_d2[p]    = d2;
    bus.host_r1[p]    = r1;
    bus.host_data[p]  = data;
    if (push) rq.push_back('{p, cyc + 1, cmd, d1, d2, r1, etag, data});
  endtask

  task automatic drive_resp(input int p, input logic [1:0] resp, input logic [TW-1:0] tag,
                            input logic [DW-1:0] data, input bit expect_cpl);
    bus.out_resp[p] = resp;
    bus.out_tag[p]  = tag;
    bus.out_data[p] = data;
    if (expect_cpl) cq.push_back('{p, cyc + 1, resp, tag, data, 1'b0});
  endtask

  task automatic push_tmo(input int p, input logic [TW-1:0] tag, input int at);
    cq.push_back('{p, at, 2'b00, tag, 32'h0, 1'b1});
  endtask

  // monitor: match every request beat / completion against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        int idx;
        idx = -1;
        if (bus.req_cmd[p] != '0) begin
          for (int i = 0; i < rq.size(); i++) if (idx < 0 && rq[i].port == p) idx = i;
          chk("req_match", idx >= 0, 1);
          if (idx >= 0) begin
            chk("req_cyc",  bus.req_cmd[p] != '0 ? cyc : -1, rq[idx].cyc);
            chk("req_cmd",  bus.req_cmd[p],  rq[idx].cmd);
            chk("req_d1",   bus.req_d1[p],   rq[idx].d1);
            chk("req_d2",   bus.req_d2[p],   rq[idx].d2);
            chk("req_r1",   bus.req_r1[p],   rq[idx].r1);
            chk("req_tag",  bus.req_tag[p],  rq[idx].tag);
            chk("req_data", bus.req_data[p], rq[idx].data);
            rq.delete(idx);
          end
        end else begin
          chk("req_idle", (bus.req_tag[p] != '0) || (bus.req_d1[p] != '0) || (bus.req_d2[p] != '0)
                          || (bus.req_r1[p] != '0) || (bus.req_data[p] != '0), 0);
        end
        idx = -1;
        if (bus.cpl_valid[p]) begin
          for (int i = 0; i < cq.size(); i++) if (idx < 0 && cq[i].port == p) idx = i;
          chk("cpl_match", idx >= 0, 1);
          if (idx >= 0) begin
            chk("cpl_cyc",  cyc,                 cq[idx].cyc);
            chk("cpl_resp", bus.cpl_resp[p],     cq[idx].resp);
            chk("cpl_tag",  bus.cpl_tag[p],      cq[idx].tag);
            chk("cpl_data", bus.cpl_data[p],     cq[idx].data);
            chk("cpl_tmo",  bus.cpl_timeout[p],  cq[idx].tmo);
            cq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.host_valid = '0; bus.host_cmd = '0; bus.host_d1 = '0; bus.host_d2 = '0;
    bus.host_r1 = '0; bus.host_data = '0;
    bus.out_resp = '0; bus.out_tag = '0; bus.out_data = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_cmd",   bus.req_cmd,      '0);
    chk("rst_cpl_valid", bus.cpl_valid,    '0);
    chk("rst_err",       bus.err_spurious, '0);
    reset = 1'b1;
    tick();
    chk("rst_ready", bus.host_ready, 4'hF);

    // 1: reset while a request beat is on the pins
    drive_host(0, 4'd5, 4'd1, 4'd1, 4'd1, 32'h5, 2'd0, 1'b0);
    drive_host(1, 4'd6, 4'd1, 4'd1, 4'd1, 32'h6, 2'd0, 1'b0);
    tick();
    chk("t1_req_pre", bus.req_cmd[0], 4'd5);
    #2 reset = 1'b0;
    #1;
    chk("t1_req_rst", bus.req_cmd,   '0);
    chk("t1_cpl_rst", bus.cpl_valid, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("t1_ready", bus.host_ready, 4'hF);
    repeat (TMO + 4) tick();   // abandoned tags must never time out

    // 2: single command and response on port 0
    drive_host(0, 4'd1, 4'd2, 4'd3, 4'd4, 32'h1234_5678, 2'd0, 1'b1);
    tick();
    drive_resp(0, 2'b01, 2'd0, 32'h0000_0055, 1'b1);
    tick();
    repeat (2) tick();

    // 3: fill port 1, free tag 2, reissue gets tag 2
    for (int i = 0; i < 4; i++) begin
      chk("t3_rdy", bus.host_ready[1], 1);
      drive_host(1, CW'(i + 2), RW'(i), RW'(i + 1), RW'(i + 2), 32'h100 + i, TW'(i), 1'b1);
      tick();
    end
    chk("t3_full", bus.host_ready[1], 0);
    drive_resp(1, 2'b10, 2'd2, 32'hC2, 1'b1);
    tick();
    chk("t3_rdy_back", bus.host_ready[1], 1);
    drive_host(1, 4'd7, 4'd7, 4'd8, 4'd9, 32'h777, 2'd2, 1'b1);
    tick();
    drive_resp(1, 2'b01, 2'd0, 32'hA0, 1'b1); tick();
    drive_resp(1, 2'b01, 2'd1, 32'hA1, 1'b1); tick();
    drive_resp(1, 2'b01, 2'd3, 32'hA3, 1'b1); tick();
    drive_resp(1, 2'b11, 2'd2, 32'hA2, 1'b1); tick();
    repeat (2) tick();

    // 4: timeout on port 2, then a late response is spurious
    drive_host(2, 4'd3, 4'd1, 4'd2, 4'd3, 32'h333, 2'd0, 1'b1);
    tick();
    push_tmo(2, 2'd0, cyc + TMO);
    repeat (TMO) tick();
    chk("t4_no_spur", bus.err_spurious, '0);
    drive_resp(2, 2'b01, 2'd0, 32'h77, 1'b0);
    tick();
    tick();
    chk("t4_spur", bus.err_spurious, 4'b0100);

    // 5: fetch on all ports at once, independent responses
    for (int p = 0; p < NP; p++)
      drive_host(p, 4'd12, RW'(p), RW'(p + 1), RW'(p + 2), 32'h500 + p, 2'd0, 1'b1);
    tick();
    for (int p = 0; p < NP; p++)
      drive_resp(p, 2'(p % 3 + 1), 2'd0, (p == 3) ? 32'hDEAD_BEEF : 32'h1000 + p, 1'b1);
    tick();
    repeat (2) tick();

    // 6: response vs expiry on the same edge; queued expiries lowest first
    drive_host(0, 4'd1, 4'd0, 4'd0, 4'd0, 32'h60, 2'd0, 1'b1);
    drive_host(3, 4'd2, 4'd0, 4'd0, 4'd0, 32'h63, 2'd0, 1'b1);
    tick();
    a = cyc;
    drive_host(0, 4'd1, 4'd1, 4'd1, 4'd1, 32'h61, 2'd1, 1'b1);
    drive_host(3, 4'd2, 4'd1, 4'd1, 4'd1, 32'h64, 2'd1, 1'b1);
    tick();
    drive_host(3, 4'd2, 4'd2, 4'd2, 4'd2, 32'h65, 2'd2, 1'b1);
    tick();
    while (cyc < a + TMO - 1) tick();
    drive_resp(0, 2'b11, 2'd0, 32'hA0, 1'b1);
    drive_resp(3, 2'b01, 2'd2, 32'hB2, 1'b1);
    push_tmo(0, 2'd1, a + TMO + 1);
    push_tmo(3, 2'd0, a + TMO + 1);
    push_tmo(3, 2'd1, a + TMO + 2);
    tick();
    repeat (TMO + 4) tick();

    chk("end_req_left", rq.size(), 0);
    chk("end_cpl_left", cq.size(), 0);
    chk("end_err",      bus.err_spurious, 4'b0100);
    chk("end_ready",    bus.host_ready, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
